// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// One transaction in flight at a time; a watchdog aborts a stalled memory access.
module dmem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_write_i,
  input  logic [NUM_REQ-1:0][31:0] req_addr_i,
  input  logic [NUM_REQ-1:0][31:0] req_wdata_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  output logic [31:0]              resp_rdata_o,
  output logic                     resp_err_o,
  output logic                     dmem_read_o,
  output logic                     dmem_write_o,
  output logic [31:0]              dmem_addr_o,
  output logic [31:0]              dmem_data_o,
  input  logic [31:0]              dmem_rd_data_i,
  input  logic                     dmem_done_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               wr_q, wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rd_p_q, rd_p_d;
  logic               wr_p_q, wr_p_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic               re_q, re_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] ready;
  logic [IDW-1:0]     win;
  logic               found;
  int                 j;

  // First valid requester at or after rr_q, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid_i[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rd_p_d  = 1'b0;
    wr_p_d  = 1'b0;
    rv_d    = '0;
    re_d    = 1'b0;
    ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ready[win] = 1'b1;
          id_d    = win;
          wr_d    = req_write_i[win];
          addr_d  = req_addr_i[win];
          data_d  = req_wdata_i[win];
          rr_d    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          rd_p_d  = !req_write_i[win];
          wr_p_d  = req_write_i[win];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dmem_done_i) begin
          rv_d[id_q] = 1'b1;
          if (!wr_q) rdata_d = dmem_rd_data_i;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rv_d[id_q] = 1'b1;
          re_d    = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      rd_p_q  <= 1'b0;
      wr_p_q  <= 1'b0;
      rv_q    <= '0;
      re_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rd_p_q  <= rd_p_d;
      wr_p_q  <= wr_p_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = ready;
  assign resp_valid_o = rv_q;
  assign resp_err_o   = re_q;
  assign resp_rdata_o = rdata_q;
  assign dmem_read_o  = rd_p_q;
  assign dmem_write_o = wr_p_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_data_o  = data_q;
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single transactions
// plus round-robin, timeout and mid-transaction reset sequences.
module tb_dmem_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_write = '0;
  logic [N-1:0][31:0] req_addr = '0;
  logic [N-1:0][31:0] req_wdata = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              dmem_read;
  logic              dmem_write;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_data;
  logic [31:0]       dmem_rd_data;
  logic              dmem_done;
  logic              busy;
  logic              err;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .dmem_read_o(dmem_read), .dmem_write_o(dmem_write),
    .dmem_addr_o(dmem_addr), .dmem_data_o(dmem_data),
    .dmem_rd_data_i(dmem_rd_data), .dmem_done_i(dmem_done),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // Memory model: done arrives in WAIT cycle lat+1; junk data otherwise.
  logic [31:0] mem [256];
  int          lat = 0;
  bit          dead = 1'b0;
  int          mcnt;
  logic        mpend;
  logic        mwr;
  logic [31:0] ma, md;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_done    <= 1'b0;
      dmem_rd_data <= '0;
      mpend        <= 1'b0;
      mcnt         <= 0;
    end else begin
      dmem_done    <= 1'b0;
      dmem_rd_data <= 32'hBAD0BAD0;
      if (dmem_read || dmem_write) begin
        ma  <= dmem_addr;
        md  <= dmem_data;
        mwr <= dmem_write;
        if (!dead) begin
          if (lat == 0) begin
            dmem_done <= 1'b1;
            if (dmem_write) mem[dmem_addr[9:2]] <= dmem_data;
            else dmem_rd_data <= mem[dmem_addr[9:2]];
          end else begin
            mcnt  <= lat;
            mpend <= 1'b1;
          end
        end
      end else if (mpend) begin
        if (mcnt == 1) begin
          dmem_done <= 1'b1;
          mpend     <= 1'b0;
          if (mwr) mem[ma[9:2]] <= md;
          else dmem_rd_data <= mem[ma[9:2]];
        end else begin
          mcnt <= mcnt - 1;
        end
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {32'(req_ready) | 32'(resp_valid) | 32'(resp_err)
            | 32'(dmem_read) | 32'(dmem_write) | 32'(busy) | 32'(err),
            resp_rdata | dmem_addr | dmem_data};
  endfunction

  task automatic do_txn(string nm, int id, bit wr, logic [31:0] a,
                        logic [31:0] wd, logic [31:0] exp_rd,
                        bit exp_re, bit exp_err, int exp_busy);
    logic [N-1:0] oh;
    int  bn;
    bit  got, bad;
    oh = '0;
    oh[id] = 1'b1;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[id]  = a;
    req_wdata[id] = wd;
    #1;
    chk({nm, " ready"}, 64'(req_ready), 64'(oh));
    @(negedge clk);
    req_valid = '0;
    chk({nm, " issue"}, {dmem_read, dmem_write, busy, dmem_addr, dmem_data},
        {!wr, wr, 1'b1, a, wd});
    bn = 1; got = 0; bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        got = 1;
        break;
      end
      if (busy) bn++;
      if (dmem_read || dmem_write || dmem_addr !== a || dmem_data !== wd)
        bad = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s no_response: got none expected resp_valid", nm);
    end else begin
      chk({nm, " wait_stable"}, 64'(bad), 64'(0));
      chk({nm, " resp"}, {resp_valid, resp_err, err, busy, resp_rdata},
          {oh, exp_re, exp_err, 1'b0, exp_rd});
      chk({nm, " busy_cycles"}, 64'(bn), 64'(exp_busy));
    end
    @(negedge clk);
    chk({nm, " one_pulse"}, {resp_valid, resp_err}, '0);
  endtask

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          lat;
  } vec_t;

  vec_t vt[6];
  int   ord[6];
  int   g;
  bit   seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    vt[0] = '{0, 1'b0, 32'h40,  32'h55AA0000, 32'hDEADBEEF, 0};
    vt[1] = '{1, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 0};
    vt[2] = '{0, 1'b0, 32'h100, 32'h55AA0002, 32'h12345678, 0};
    vt[3] = '{1, 1'b1, 32'h200, 32'hCAFEF00D, 32'h12345678, 5};
    vt[4] = '{1, 1'b0, 32'h200, 32'h55AA0004, 32'hCAFEF00D, 2};
    vt[5] = '{0, 1'b0, 32'h3C,  32'h55AA0005, 32'h00000000, 1};

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_outputs", all_outs(), '0);

    for (int i = 0; i < 6; i++) begin
      lat = vt[i].lat;
      do_txn($sformatf("vec%0d", i), vt[i].id, vt[i].wr, vt[i].addr,
             vt[i].wdata, vt[i].exp_rd, 1'b0, 1'b0, vt[i].lat + 2);
    end

    // Reset in WAIT: rr pointer now points at requester 1
    dead = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h80;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    dead  = 1'b0;
    seen  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid != '0 || busy) seen = 1'b1;
    end
    chk("no_resp_after_reset", 64'(seen), 64'(0));

    // Round robin with both requesters held valid
    lat = 0;
    g = 0;
    req_write = '0;
    req_addr[0] = 32'h40;
    req_addr[1] = 32'h100;
    req_valid = 2'b11;
    for (int c = 0; c < 200 && g < 6; c++) begin
      #1;
      if (req_ready != '0) begin
        ord[g] = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
        g++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_grant_count", 64'(g), 64'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_grant%0d", i), 64'(ord[i]), 64'(i % 2));
    repeat (6) @(negedge clk);

    // Watchdog abort, then normal service with sticky err_o
    dead = 1'b1;
    do_txn("timeout", 1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1, TO + 1);
    dead = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(err), 64'(1));
    do_txn("post_timeout", 0, 1'b0, 32'h40, 32'h1, 32'hDEADBEEF,
           1'b0, 1'b1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares the single-ported data-memory model among NUM_REQ requesters, for example the load unit and the store/commit unit.
- Accepts one request at a time and issues it to memory as a one-cycle read or write start pulse.
- Holds the address and write data stable until memory signals done, then returns a one-cycle response to the winning requester.
- Includes a watchdog that aborts a transaction if memory never signals done.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, number of WAIT cycles without dmem_done_i before the transaction is aborted (>=2).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_write_i  in  NUM_REQ  per-requester op: 1 = store, 0 = load.
- req_addr_i  in  NUM_REQ x 32  per-requester byte address.
- req_wdata_i  in  NUM_REQ x 32  per-requester store data.
- req_ready_o  out  NUM_REQ  one-hot grant/accept; combinational.
- resp_valid_o  out  NUM_REQ  one-hot response pulse; registered.
- resp_rdata_o  out  32  load data, shared by all requesters.
- resp_err_o  out  1  the response in this cycle is a timeout abort.
- dmem_read_o  out  1  memory read start pulse.
- dmem_write_o  out  1  memory write start pulse.
- dmem_addr_o  out  32  memory address.
- dmem_data_o  out  32  memory store data.
- dmem_rd_data_i  in  32  memory load data.
- dmem_done_i  in  1  memory operation complete.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync deassert assumed external): state=IDLE, rr_ptr=0, timeout counter=0, latched id/op/addr/data=0.
  - All outputs are 0 during and after reset, including resp_rdata_o and err_o.
  - Reset mid-transaction drops the transaction silently; no response is issued.
- State machine: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid_i bit is set, pick winner w = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Assert req_ready_o[w] in the same cycle; this completes the handshake.
  - Latch w, req_write_i[w], req_addr_i[w], req_wdata_i[w]; set rr_ptr = (w+1) mod NUM_REQ; next state ISSUE.
  - If no request is valid, stay in IDLE; req_ready_o=0.
- ISSUE:
  - For exactly one cycle, drive dmem_read_o=1 (load) or dmem_write_o=1 (store).
  - dmem_addr_o and dmem_data_o come from the latched values. Next state WAIT; timeout counter cleared.
- WAIT:
  - dmem_read_o and dmem_write_o are 0; dmem_addr_o and dmem_data_o are held unchanged.
  - When dmem_done_i=1:
    - Next cycle: resp_valid_o[id]=1 for exactly one cycle.
    - For loads, resp_rdata_o <= dmem_rd_data_i, captured in the done cycle. resp_rdata_o keeps its value until the next load response; stores do not update it.
    - Next state IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no done:
    - Next cycle: resp_valid_o[id]=1, resp_err_o=1, resp_rdata_o=0.
    - err_o is set and stays set until reset. Next state IDLE.
- dmem_done_i in IDLE or ISSUE is ignored.
- req_ready_o is only ever asserted in IDLE, so at most one bit is set.
  - A requester keeps its valid, address and data stable until it sees ready.
  - A requester may drop valid before ready; this is legal and the request is not granted.
- The response pulse coincides with the IDLE cycle after WAIT, so a new grant may occur in that same cycle.
  - Minimum occupancy is 4 cycles per operation with a 1-cycle-latency memory: IDLE, ISSUE, WAIT(done), then IDLE/resp.
- dmem_addr_o is passed through unmodified; word alignment is handled by the memory.
- Fairness: a requester held valid is granted within NUM_REQ grants.

Test Plan:
- Single load: memory pre-written 0xDEADBEEF at 0x40.
  - Stimulus: req 0 loads 0x40.
  - Required: req_ready_o=01 at cycle T, dmem_read_o=1 at T+1 with addr 0x40, resp_valid_o=01 with resp_rdata_o=0xDEADBEEF the cycle after done.
- Store then load:
  - Stimulus: req 1 stores 0x12345678 to 0x100, then req 0 loads 0x100.
  - Required: dmem_write_o pulses once with data 0x12345678; the load returns 0x12345678; resp_rdata_o is unchanged by the store response.
- Round-robin: both requesters held valid for 6 grants from reset.
  - Required: grant order 0,1,0,1,0,1; no requester is granted twice consecutively while the other waits.
- Memory LATENCY=5:
  - Required: dmem_addr_o and dmem_data_o are stable for all WAIT cycles; exactly one start pulse per transaction; busy_o is high for 7 cycles.
- Timeout: TIMEOUT=8, memory never asserts done.
  - Required: after 8 WAIT cycles, resp_valid_o pulses for the requester with resp_err_o=1 and resp_rdata_o=0; err_o stays 1; the next request is then serviced normally.
- Reset during WAIT:
  - Required: all outputs go to 0 asynchronously; no resp_valid_o after release; the next request is granted to requester 0 first (rr_ptr=0).
